// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST accelerator.
// Holds the layer-sequencer state encoding and the address-width helper used by the weight ROM.
package mnist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        DRAIN = 3'd2,
        FIRE  = 3'd3,
        HOLD  = 3'd4
    } seq_state_t;

    // A single-entry range still needs a one-bit index, so the width never drops to zero.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned MNIST_NUM_INPUTS = 784;
    localparam int unsigned MNIST_ADDR_WIDTH = clog2_min1(MNIST_NUM_INPUTS);

endpackage

// File: rtl/relu_layer_sequencer.sv
// Per-frame controller for one fully-connected layer: streams activations into the MAC array,
// waits out the MAC latency, fires the ReLU capture and holds the result for the next layer.
module relu_layer_sequencer
    import mnist_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 784,
    parameter int unsigned MAC_LAT    = 2,
    parameter int unsigned ADDR_WIDTH = clog2_min1(NUM_INPUTS),
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  start_ready,
    input  logic                  abort,
    input  logic                  x_valid,
    output logic                  x_ready,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic                  mac_last,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  relu_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

    localparam int unsigned DRAIN_WIDTH = clog2_min1(MAC_LAT);
    localparam logic [ADDR_WIDTH-1:0]  LAST_BEAT  = ADDR_WIDTH'(NUM_INPUTS - 1);
    localparam logic [DRAIN_WIDTH-1:0] LAST_DRAIN = DRAIN_WIDTH'((MAC_LAT == 0) ? 0 : MAC_LAT - 1);

    seq_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  beat_q, beat_d;
    logic [DRAIN_WIDTH-1:0] drain_q, drain_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            drain_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            drain_q     <= drain_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        drain_d     = drain_q;
        frame_cnt_d = frame_cnt_q;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        mac_last    = 1'b0;

        if (abort) begin
            state_d = IDLE;
            beat_d  = '0;
            drain_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mac_clr = 1'b1;
                        beat_d  = '0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (x_valid) begin
                        mac_en = 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            mac_last = 1'b1;
                            beat_d   = '0;
                            state_d  = (MAC_LAT > 0) ? DRAIN : FIRE;
                        end else begin
                            beat_d = beat_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == LAST_DRAIN) begin
                        drain_d = '0;
                        state_d = FIRE;
                    end else begin
                        drain_d = drain_q + DRAIN_WIDTH'(1);
                    end
                end
                FIRE: state_d = HOLD;
                HOLD: begin
                    if (out_ready) begin
                        frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign x_ready     = (state_q == ACCUM);
    assign out_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign w_addr      = beat_q;
    assign frame_cnt   = frame_cnt_q;
    // An abort landing on the FIRE cycle must still suppress the ReLU capture.
    assign relu_valid  = (state_q == FIRE) && !abort;

endmodule

// File: tb/tb_relu_layer_sequencer.sv
// Directed bench for relu_layer_sequencer: a 4-input/2-latency instance covers the frame flow,
// and a 1-input/0-latency instance covers the degenerate timing corner.
module tb_relu_layer_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 0, abort_a = 0, x_valid_a = 0, out_ready_a = 0;
    logic       start_ready_a, x_ready_a, mac_clr_a, mac_en_a, mac_last_a;
    logic       relu_valid_a, out_valid_a, busy_a;
    logic [1:0] w_addr_a;
    logic [3:0] frame_cnt_a;

    logic       start_b = 0, abort_b = 0, x_valid_b = 0, out_ready_b = 0;
    logic       start_ready_b, x_ready_b, mac_clr_b, mac_en_b, mac_last_b;
    logic       relu_valid_b, out_valid_b, busy_b;
    logic [0:0] w_addr_b;
    logic [3:0] frame_cnt_b;

    relu_layer_sequencer #(.NUM_INPUTS(4), .MAC_LAT(2), .CNT_WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .start_ready(start_ready_a), .abort(abort_a),
        .x_valid(x_valid_a), .x_ready(x_ready_a), .mac_clr(mac_clr_a), .mac_en(mac_en_a),
        .mac_last(mac_last_a), .w_addr(w_addr_a), .relu_valid(relu_valid_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .busy(busy_a), .frame_cnt(frame_cnt_a)
    );

    relu_layer_sequencer #(.NUM_INPUTS(1), .MAC_LAT(0), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .start_ready(start_ready_b), .abort(abort_b),
        .x_valid(x_valid_b), .x_ready(x_ready_b), .mac_clr(mac_clr_b), .mac_en(mac_en_b),
        .mac_last(mac_last_b), .w_addr(w_addr_b), .relu_valid(relu_valid_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b), .frame_cnt(frame_cnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One cycle: drive after the rising edge, leave outputs to be sampled at the falling edge.
    task automatic cyc_a(input logic s, input logic xv, input logic orr, input logic ab);
        @(posedge clk);
        #1;
        start_a = s; x_valid_a = xv; out_ready_a = orr; abort_a = ab;
        @(negedge clk);
    endtask

    task automatic cyc_b(input logic s, input logic xv, input logic orr, input logic ab);
        @(posedge clk);
        #1;
        start_b = s; x_valid_b = xv; out_ready_b = orr; abort_b = ab;
        @(negedge clk);
    endtask

    task automatic run_frame_a();
        cyc_a(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc_a(0, 1, 1, 0);
        cyc_a(0, 0, 1, 0);
        cyc_a(0, 0, 1, 0);
        cyc_a(0, 0, 1, 0);
        check("wrap_relu_fire", relu_valid_a, 1);
        cyc_a(0, 0, 1, 0);
        cyc_a(0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic       stall_pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [1:0] stall_addr[7] = '{0, 1, 1, 1, 2, 3, 3};
        int         en_count;

        // Reset state
        @(negedge clk);
        check("rst_start_ready", start_ready_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_w_addr", w_addr_a, 0);
        check("rst_frame_cnt", frame_cnt_a, 0);
        check("rst_pulses", {mac_clr_a, mac_en_a, mac_last_a, relu_valid_a, out_valid_a, x_ready_a}, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Reset asserted mid-ACCUM
        cyc_a(1, 0, 1, 0);
        cyc_a(0, 1, 1, 0);
        cyc_a(0, 1, 1, 0);
        check("midrst_pre_w_addr", w_addr_a, 1);
        #1 rst = 1'b0;
        #1;
        check("midrst_start_ready", start_ready_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_frame_cnt", frame_cnt_a, 0);
        check("midrst_w_addr", w_addr_a, 0);
        check("midrst_pulses", {mac_clr_a, mac_en_a, mac_last_a, relu_valid_a, out_valid_a, x_ready_a}, 0);
        x_valid_a = 0;
        @(posedge clk);
        #1 rst = 1'b1;

        // Nominal frame
        cyc_a(1, 0, 1, 0);
        check("nom_mac_clr", mac_clr_a, 1);
        for (int i = 0; i < 4; i++) begin
            cyc_a(0, 1, 1, 0);
            check("nom_x_ready", x_ready_a, 1);
            check("nom_mac_en", mac_en_a, 1);
            check("nom_w_addr", w_addr_a, i);
            check("nom_mac_last", mac_last_a, (i == 3));
        end
        cyc_a(0, 0, 1, 0);
        check("nom_drain0", {busy_a, relu_valid_a, x_ready_a}, 3'b100);
        cyc_a(0, 0, 1, 0);
        check("nom_drain1", relu_valid_a, 0);
        cyc_a(0, 0, 1, 0);
        check("nom_relu_c7", relu_valid_a, 1);
        cyc_a(0, 0, 1, 0);
        check("nom_out_valid_c8", out_valid_a, 1);
        check("nom_relu_c8", relu_valid_a, 0);
        cyc_a(0, 0, 0, 0);
        check("nom_frame_cnt_c9", frame_cnt_a, 1);
        check("nom_idle_c9", {start_ready_a, out_valid_a}, 2'b10);

        // Stalls, then backpressure in HOLD
        cyc_a(1, 0, 0, 0);
        en_count = 0;
        for (int i = 0; i < 7; i++) begin
            cyc_a(0, stall_pat[i], 0, 0);
            check("stall_w_addr", w_addr_a, stall_addr[i]);
            check("stall_mac_en", mac_en_a, stall_pat[i]);
            if (mac_en_a) en_count++;
        end
        check("stall_en_count", en_count, 4);
        check("stall_mac_last", mac_last_a, 1);
        cyc_a(0, 0, 0, 0);
        check("stall_relu_l1", relu_valid_a, 0);
        cyc_a(0, 0, 0, 0);
        check("stall_relu_l2", relu_valid_a, 0);
        cyc_a(0, 0, 0, 0);
        check("stall_relu_l3", relu_valid_a, 1);
        for (int i = 0; i < 5; i++) begin
            cyc_a(1, 0, 0, 0);
            check("bp_out_valid", out_valid_a, 1);
            check("bp_start_ready", start_ready_a, 0);
            check("bp_mac_clr", mac_clr_a, 0);
        end
        cyc_a(0, 0, 1, 0);
        check("bp_out_valid_6", out_valid_a, 1);
        cyc_a(0, 0, 0, 0);
        check("bp_out_valid_done", out_valid_a, 0);
        check("bp_frame_cnt", frame_cnt_a, 2);

        // Abort wins over start in IDLE
        cyc_a(1, 0, 0, 1);
        check("abort_idle_mac_clr", mac_clr_a, 0);
        cyc_a(0, 0, 0, 0);
        check("abort_idle_stays", {start_ready_a, busy_a}, 2'b10);

        // Abort during DRAIN
        cyc_a(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc_a(0, 1, 0, 0);
        cyc_a(0, 0, 0, 1);
        check("abort_drain_relu", relu_valid_a, 0);
        cyc_a(0, 0, 0, 0);
        check("abort_drain_idle", {start_ready_a, busy_a}, 2'b10);
        check("abort_drain_cnt", frame_cnt_a, 2);
        cyc_a(0, 0, 0, 0);
        check("abort_drain_no_relu", relu_valid_a, 0);

        // Abort with out_ready in HOLD
        cyc_a(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc_a(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc_a(0, 0, 0, 0);
        cyc_a(0, 0, 1, 1);
        check("abort_hold_out_valid", out_valid_a, 1);
        cyc_a(0, 0, 0, 0);
        check("abort_hold_cnt", frame_cnt_a, 2);
        check("abort_hold_idle", start_ready_a, 1);

        // Frame counter wrap: 2 + 14 completed frames
        for (int i = 0; i < 13; i++) run_frame_a();
        check("wrap_cnt_15", frame_cnt_a, 15);
        run_frame_a();
        check("wrap_cnt_0", frame_cnt_a, 0);

        // NUM_INPUTS=1, MAC_LAT=0
        cyc_b(1, 0, 1, 0);
        check("b_mac_clr", mac_clr_b, 1);
        check("b_mac_last_start", mac_last_b, 0);
        cyc_b(0, 1, 1, 0);
        check("b_mac_last", mac_last_b, 1);
        check("b_mac_en", mac_en_b, 1);
        check("b_mac_clr_beat", mac_clr_b, 0);
        check("b_w_addr", w_addr_b, 0);
        cyc_b(0, 0, 1, 0);
        check("b_relu_next", relu_valid_b, 1);
        cyc_b(0, 0, 1, 0);
        check("b_out_valid", out_valid_b, 1);
        cyc_b(0, 0, 0, 0);
        check("b_frame_cnt", frame_cnt_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
